// File: rtl/parity_pipe.sv
// ---------------------------------------------------------------------------
// parity_pipe
//   Streaming, pipelined parity generator/checker. Each beat of DATA_W bits
//   is split into NGRP = DATA_W/GROUP_W groups and one parity bit is
//   produced per group. The sense (odd/even) and the mode (generate/check)
//   are sampled with every beat. The per-group XOR trees are spread over
//   PIPE_STAGES register stages, so the latency is PIPE_STAGES cycles and
//   the throughput is one beat per cycle. A saturating counter counts the
//   errored beats that leave the block.
//
// Parameters
//   DATA_W      data width, a multiple of GROUP_W
//   GROUP_W     bits per parity group, a power of 2, >= 2
//   PIPE_STAGES register stages (= latency), 1..4
//   CNT_W       error counter width
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   input beat valid
//   in_ready   out  block can accept a beat
//   in_data    in   payload
//   in_par     in   received parity, one bit per group (check mode only)
//   in_odd     in   1 = odd parity, 0 = even parity (per beat)
//   in_chk     in   1 = check mode, 0 = generate mode (per beat)
//   out_valid  out  output beat valid
//   out_ready  in   sink accepts the beat
//   out_data   out  in_data delayed by the pipeline
//   out_par    out  computed parity, bit g covers group g
//   out_err    out  per-group mismatch in check mode, else 0
//   err_any    out  OR of out_err, qualified by out_valid
//   cnt_clr    in   synchronous clear of err_cnt
//   err_cnt    out  saturating count of errored output beats
//
// Handshake (both ports): a transfer happens on a rising edge where valid
// and ready are both 1. The output side holds out_valid and all payload
// outputs stable while out_valid && !out_ready (stall); during a stall every
// stage holds and in_ready is 0. in_ready does not depend on in_valid.
// ---------------------------------------------------------------------------
module parity_pipe #(
    parameter int DATA_W      = 32,
    parameter int GROUP_W     = 8,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [DATA_W/GROUP_W-1:0]   in_par,
    input  logic                        in_odd,
    input  logic                        in_chk,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [DATA_W/GROUP_W-1:0]   out_par,
    output logic [DATA_W/GROUP_W-1:0]   out_err,
    output logic                        err_any,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            err_cnt
);

    localparam int NGRP  = DATA_W / GROUP_W;
    localparam int LOG_G = $clog2(GROUP_W);
    localparam int LAST  = PIPE_STAGES - 1;

    // Number of XOR-tree levels completed once a beat has passed s stages.
    // Levels are spread as evenly as possible; the last stage always
    // finishes the tree.
    function automatic int levels_done(input int s);
        return (s * LOG_G + PIPE_STAGES - 1) / PIPE_STAGES;
    endfunction

    // One tree level. Within every group slot the live partial results sit
    // in the low bits; this level pairs them up and halves the live width.
    // Bits above the live width are forced to zero.
    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] v,
                                               input int lvl);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int g = 0; g < NGRP; g++) begin
            for (int i = 0; i < GROUP_W / 2; i++) begin
                if (i < (GROUP_W >> (lvl + 1))) begin
                    r[g*GROUP_W + i] = v[g*GROUP_W + 2*i] ^ v[g*GROUP_W + 2*i + 1];
                end
            end
        end
        return r;
    endfunction

    // Stage registers
    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] odd_q;
    logic [PIPE_STAGES-1:0] chk_q;
    logic [DATA_W-1:0]      data_q [PIPE_STAGES];
    logic [DATA_W-1:0]      tree_q [PIPE_STAGES];
    logic [NGRP-1:0]        par_q  [PIPE_STAGES];
    logic [DATA_W-1:0]      tree_d [PIPE_STAGES];

    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    logic                   stall;
    logic                   advance;

    assign stall    = vld_q[LAST] && !out_ready;
    assign advance  = !stall;
    assign in_ready = !stall && !rst;

    // Tree levels evaluated in front of each stage register.
    always_comb begin
        logic [DATA_W-1:0] t;
        t = '0;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            t = (s == 0) ? in_data : tree_q[(s == 0) ? 0 : s - 1];
            for (int l = 0; l < LOG_G; l++) begin
                if (l >= levels_done(s) && l < levels_done(s + 1)) begin
                    t = fold(t, l);
                end
            end
            tree_d[s] = t;
        end
    end

    // Whole-pipeline advance. Payload fields only load when a valid beat
    // moves in, so a bubble reaching the last stage leaves the previous
    // beat's outputs in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            odd_q <= '0;
            chk_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_q[s] <= '0;
                tree_q[s] <= '0;
                par_q[s]  <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
                tree_q[0] <= tree_d[0];
                par_q[0]  <= in_par;
                odd_q[0]  <= in_odd;
                chk_q[0]  <= in_chk;
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                    tree_q[s] <= tree_d[s];
                    par_q[s]  <= par_q[s-1];
                    odd_q[s]  <= odd_q[s-1];
                    chk_q[s]  <= chk_q[s-1];
                end
            end
        end
    end

    // After the last stage only bit 0 of each group slot is non-zero, so the
    // slot reduction below is the finished group XOR.
    always_comb begin
        out_par = '0;
        for (int g = 0; g < NGRP; g++) begin
            out_par[g] = (^tree_q[LAST][g*GROUP_W +: GROUP_W]) ^ odd_q[LAST];
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_err   = chk_q[LAST] ? (out_par ^ par_q[LAST]) : '0;
    assign err_any   = out_valid && (|out_err);

    // Error counter: clear wins over increment; saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && err_any && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_parity_pipe.sv
// ---------------------------------------------------------------------------
// tb_parity_pipe
//   Directed bench for parity_pipe. Two instances share one stimulus:
//   u_w has a single 32-bit group, u_b has byte groups and a 2-bit error
//   counter. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_parity_pipe;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [0:0]  in_par_w;
    logic [3:0]  in_par_b;
    logic        in_odd;
    logic        in_chk;
    logic        out_ready;
    logic        cnt_clr;

    logic        w_in_ready, w_out_valid, w_err_any;
    logic [31:0] w_out_data;
    logic [0:0]  w_out_par, w_out_err;
    logic [15:0] w_err_cnt;

    logic        b_in_ready, b_out_valid, b_err_any;
    logic [31:0] b_out_data;
    logic [3:0]  b_out_par, b_out_err;
    logic [1:0]  b_err_cnt;

    parity_pipe #(.DATA_W(32), .GROUP_W(32), .PIPE_STAGES(2), .CNT_W(16)) u_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_data(in_data), .in_par(in_par_w), .in_odd(in_odd), .in_chk(in_chk),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .out_par(w_out_par), .out_err(w_out_err), .err_any(w_err_any),
        .cnt_clr(cnt_clr), .err_cnt(w_err_cnt)
    );

    parity_pipe #(.DATA_W(32), .GROUP_W(8), .PIPE_STAGES(2), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_par(in_par_b), .in_odd(in_odd), .in_chk(in_chk),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_par(b_out_par), .out_err(b_out_err), .err_any(b_err_any),
        .cnt_clr(cnt_clr), .err_cnt(b_err_cnt)
    );

    // Scoreboard
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Even byte parity of a word (bit g = XOR of byte g).
    function automatic logic [3:0] par_even(input logic [31:0] d);
        logic [3:0] p;
        for (int g = 0; g < 4; g++) p[g] = ^d[g*8 +: 8];
        return p;
    endfunction

    logic [31:0] bp_data [6];
    int          sent, recv;
    logic        stall_now, prev_stall;
    logic [31:0] prev_data, expd;
    logic [3:0]  prev_par;
    logic [1:0]  cnt_exp [6];

    initial begin
        bp_data = '{32'h0000_0001, 32'h0000_0003, 32'hFF00_FF00,
                    32'h8000_0001, 32'h1234_5678, 32'hDEAD_BEEF};
        cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par_w = '0; in_par_b = '0;
        in_odd = 1'b0; in_chk = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_out_valid", b_out_valid, 0);
        check("rst_in_ready",  b_in_ready, 0);
        check("rst_err_cnt",   b_err_cnt, 0);
        check("rst_out_par",   b_out_par, 0);
        check("rst_out_data",  b_out_data, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", b_in_ready, 1);

        // Single 32-bit group, odd, generate: 0, 1, all-ones back to back
        in_odd = 1'b1; in_chk = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0000;
        tick();
        in_data = 32'h0000_0001;
        tick();
        check("t1_valid0", w_out_valid, 1);
        check("t1_par0",   w_out_par, 1);
        check("t1_data0",  w_out_data, 32'h0000_0000);
        in_data = 32'hFFFF_FFFF;
        tick();
        check("t1_par1",   w_out_par, 0);
        check("t1_data1",  w_out_data, 32'h0000_0001);
        in_valid = 1'b0;
        tick();
        check("t1_par2",   w_out_par, 1);
        check("t1_data2",  w_out_data, 32'hFFFF_FFFF);
        tick();
        check("t1_bubble_valid", w_out_valid, 0);
        check("t1_bubble_any",   w_err_any, 0);
        check("t1_hold_par",     w_out_par, 1);
        check("t1_hold_data",    w_out_data, 32'hFFFF_FFFF);

        // Same word 1 in even mode
        in_odd = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        tick();
        check("t1_even_valid", w_out_valid, 1);
        check("t1_even_par",   w_out_par, 1);
        check("t1_even_bytes", b_out_par, 4'b0001);

        // Byte groups, even, generate; in_par must be ignored
        in_odd = 1'b0; in_chk = 1'b0; in_data = 32'h0103_0700; in_par_b = 4'b1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t2_valid",   b_out_valid, 1);
        check("t2_par",     b_out_par, 4'b1010);
        check("t2_err",     b_out_err, 4'b0000);
        check("t2_err_any", b_err_any, 0);

        // Byte groups, odd, check: correct parity then one bad group
        in_odd = 1'b1; in_chk = 1'b1; in_data = 32'h0103_0700; in_par_b = 4'b0101;
        in_valid = 1'b1;
        tick();
        in_par_b = 4'b0100;
        tick();
        in_valid = 1'b0;
        check("t3_par_ok",     b_out_par, 4'b0101);
        check("t3_err_ok",     b_out_err, 4'b0000);
        check("t3_any_ok",     b_err_any, 0);
        check("t3_cnt_ok",     b_err_cnt, 0);
        tick();
        check("t3_err_bad",    b_out_err, 4'b0001);
        check("t3_any_bad",    b_err_any, 1);
        check("t3_cnt_before", b_err_cnt, 0);
        tick();
        check("t3_cnt_after",  b_err_cnt, 1);
        check("t3_idle_valid", b_out_valid, 0);
        check("t3_idle_any",   b_err_any, 0);

        // Counter clear, then saturation of the 2-bit counter
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("t5_clr", b_err_cnt, 0);
        in_odd = 1'b1; in_chk = 1'b1; in_data = 32'h0103_0700; in_par_b = 4'b0100;
        for (int c = 0; c <= 8; c++) begin
            if (c >= 3) check($sformatf("t5_cnt_c%0d", c), b_err_cnt, cnt_exp[c-3]);
            in_valid = (c < 6);
            cnt_clr  = (c == 7);
            tick();
        end
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        check("t5_cnt_final", b_err_cnt, 0);

        // Backpressure: 6 beats, out_ready low for 3 cycles mid-stream
        in_odd = 1'b0; in_chk = 1'b0;
        sent = 0; recv = 0; prev_stall = 1'b0; prev_data = '0; prev_par = '0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            out_ready = !(c >= 4 && c < 7);
            in_valid  = (sent < 6);
            if (sent < 6) in_data = bp_data[sent];
            #1;
            stall_now = b_out_valid && !out_ready;
            if (stall_now) check("bp_in_ready_low", b_in_ready, 0);
            if (stall_now && prev_stall) begin
                check("bp_hold_data", b_out_data, prev_data);
                check("bp_hold_par",  b_out_par, prev_par);
            end
            if (b_out_valid && out_ready) begin
                check("bp_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    expd = exp_q.pop_front();
                    check("bp_data", b_out_data, expd);
                    check("bp_par",  b_out_par, par_even(expd));
                end
                recv++;
            end
            if (in_valid && b_in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            prev_stall = stall_now;
            prev_data  = b_out_data;
            prev_par   = b_out_par;
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check("bp_recv_count", recv, 6);
        check("bp_queue_empty", 32'(exp_q.size()), 0);

        // Reset with two errored beats in flight
        in_odd = 1'b1; in_chk = 1'b1; in_par_b = 4'b0100;
        in_data = 32'h0103_0700; in_valid = 1'b1;
        tick();
        in_data = 32'h0000_00FF;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("r6_in_ready_rst", b_in_ready, 0);
        tick();
        rst = 1'b0;
        check("r6_out_valid", b_out_valid, 0);
        check("r6_err_cnt",   b_err_cnt, 0);
        check("r6_out_data",  b_out_data, 0);
        check("r6_err_any",   b_err_any, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("r6_no_stale", b_out_valid, 0);
        end
        in_odd = 1'b0; in_chk = 1'b0; in_data = 32'h0103_0700; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("r6_lat_early", b_out_valid, 0);
        tick();
        check("r6_lat_valid", b_out_valid, 1);
        check("r6_lat_data",  b_out_data, 32'h0103_0700);
        check("r6_lat_par",   b_out_par, 4'b1010);
        tick();
        check("r6_single_beat", b_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
